seg_capture_decoder: RTL and testbench

Receive-side counterpart of the multiplexed seven-segment display path. The block samples the active-low segment bus `seg` and the active-low digit-select bus `an`. It decodes each stable segment pattern back into a digit code and assembles the four digits into a frame. It also reconstructs the decimal value shown on digits 2..0. The block is used for loopback self-test of the display driver on the board and as a monitor in display-path benches.

---
 rtl/seg_codes_pkg.sv | 57 +++++
 rtl/seg_pattern_decode.sv | 37 +++
 rtl/seg_capture_decoder.sv | 139 +++++++++++++
 tb/tb_seg_capture_decoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_codes_pkg.sv
`default_nettype none
// seg_codes_pkg: seven-segment glyphs, digit codes, FSM states and small helpers
// shared by the segment capture/decode path.
package seg_codes_pkg;

  localparam logic [6:0] GLYPH_0    = 7'b0000001;
  localparam logic [6:0] GLYPH_1    = 7'b1001111;
  localparam logic [6:0] GLYPH_2    = 7'b0010010;
  localparam logic [6:0] GLYPH_3    = 7'b0000110;
  localparam logic [6:0] GLYPH_4    = 7'b1001100;
  localparam logic [6:0] GLYPH_5    = 7'b0100100;
  localparam logic [6:0] GLYPH_6    = 7'b0100000;
  localparam logic [6:0] GLYPH_7    = 7'b0001111;
  localparam logic [6:0] GLYPH_8    = 7'b0000000;
  localparam logic [6:0] GLYPH_9    = 7'b0000100;
  localparam logic [6:0] GLYPH_A    = 7'b0001000;
  localparam logic [6:0] GLYPH_B    = 7'b1100000;
  localparam logic [6:0] GLYPH_C    = 7'b0110001;
  localparam logic [6:0] GLYPH_D    = 7'b1000010;
  localparam logic [6:0] GLYPH_E    = 7'b0110000;
  localparam logic [6:0] GLYPH_F    = 7'b0111000;
  localparam logic [6:0] GLYPH_OFF  = 7'b1111111;
  localparam logic [6:0] GLYPH_DASH = 7'b1111110;

  localparam logic [4:0] CODE_OFF     = 5'd16;
  localparam logic [4:0] CODE_DASH    = 5'd17;
  localparam logic [4:0] CODE_INVALID = 5'd31;

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE   = 2'd0;
  localparam fsm_state_t ST_SETTLE = 2'd1;
  localparam fsm_state_t ST_HELD   = 2'd2;

  function automatic logic onehot_low(input logic [3:0] an_n);
    return $onehot(~an_n);
  endfunction

  function automatic logic [1:0] sel_index(input logic [3:0] an_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!an_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // OFF is treated as a blank leading digit, i.e. numeric zero.
  function automatic logic is_numeric(input logic [4:0] c);
    return (c < 5'd10) || (c == CODE_OFF);
  endfunction

  function automatic logic [3:0] numeric_value(input logic [4:0] c);
    return (c < 5'd10) ? c[3:0] : 4'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_pattern_decode.sv
`default_nettype none
// seg_pattern_decode: maps an active-low 7-bit segment pattern (a..g = [6:0])
// to a 5-bit digit code; unknown patterns decode to CODE_INVALID.
module seg_pattern_decode
  import seg_codes_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [4:0] code
);

  always_comb begin
    code = CODE_INVALID;
    case (pattern)
      GLYPH_0:    code = 5'd0;
      GLYPH_1:    code = 5'd1;
      GLYPH_2:    code = 5'd2;
      GLYPH_3:    code = 5'd3;
      GLYPH_4:    code = 5'd4;
      GLYPH_5:    code = 5'd5;
      GLYPH_6:    code = 5'd6;
      GLYPH_7:    code = 5'd7;
      GLYPH_8:    code = 5'd8;
      GLYPH_9:    code = 5'd9;
      GLYPH_A:    code = 5'd10;
      GLYPH_B:    code = 5'd11;
      GLYPH_C:    code = 5'd12;
      GLYPH_D:    code = 5'd13;
      GLYPH_E:    code = 5'd14;
      GLYPH_F:    code = 5'd15;
      GLYPH_OFF:  code = CODE_OFF;
      GLYPH_DASH: code = CODE_DASH;
      default:    code = CODE_INVALID;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_capture_decoder.sv
`default_nettype none
// seg_capture_decoder: samples a multiplexed seven-segment bus, captures each digit
// once its select has been stable SETTLE cycles, and assembles frames and a decimal value.
module seg_capture_decoder
  import seg_codes_pkg::*;
#(
  parameter int SETTLE = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  input  logic [3:0] an,
  output logic [4:0] digit0,
  output logic [4:0] digit1,
  output logic [4:0] digit2,
  output logic [4:0] digit3,
  output logic       frame_done,
  output logic [9:0] value,
  output logic       value_ok,
  output logic       err
);

  localparam logic [15:0] SETTLE_CNT = 16'(SETTLE);

  logic [6:0]  seg_q;
  logic [3:0]  an_q;
  logic [3:0]  an_prev;
  fsm_state_t  state;
  logic [15:0] cnt;
  logic [4:0]  digit_r [4];
  logic [3:0]  seen;

  logic [4:0]  code;
  logic        an_changed;
  logic        an_valid;
  logic        capture;
  logic [1:0]  sel;
  logic        ok_next;
  logic [9:0]  value_next;

  seg_pattern_decode u_decode (
    .pattern (seg_q),
    .code    (code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q   <= GLYPH_OFF;
      an_q    <= 4'hF;
      an_prev <= 4'hF;
    end else begin
      seg_q   <= seg;
      an_q    <= an;
      an_prev <= an_q;
    end
  end

  assign an_changed = (an_q != an_prev);
  assign an_valid   = onehot_low(an_q);
  assign sel        = sel_index(an_q);
  // A select change on the terminal count wins over the capture.
  assign capture    = !an_changed && (state == ST_SETTLE) && (cnt == SETTLE_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 16'd0;
    end else if (an_changed) begin
      if (an_valid) begin
        state <= ST_SETTLE;
        cnt   <= 16'd1;
      end else begin
        state <= ST_IDLE;
        cnt   <= 16'd0;
      end
    end else begin
      case (state)
        ST_SETTLE: begin
          if (cnt == SETTLE_CNT) begin
            state <= ST_HELD;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_HELD: state <= ST_HELD;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) digit_r[i] <= CODE_OFF;
    end else if (capture) begin
      digit_r[sel] <= code;
    end
  end

  assign ok_next    = is_numeric(digit_r[2]) && is_numeric(digit_r[1]) && is_numeric(digit_r[0]);
  assign value_next = ok_next
                    ? (10'(numeric_value(digit_r[2])) * 10'd100
                       + 10'(numeric_value(digit_r[1])) * 10'd10
                       + 10'(numeric_value(digit_r[0])))
                    : 10'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      seen       <= 4'b0000;
      frame_done <= 1'b0;
      value      <= 10'd0;
      value_ok   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (seen == 4'hF) begin
        frame_done <= 1'b1;
        value      <= value_next;
        value_ok   <= ok_next;
        seen       <= capture ? (4'b0001 << sel) : 4'b0000;
      end else if (capture) begin
        seen <= seen | (4'b0001 << sel);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((capture && (code == CODE_INVALID)) || (!an_valid && (an_q != 4'hF))) begin
      err <= 1'b1;
    end
  end

  assign digit0 = digit_r[0];
  assign digit1 = digit_r[1];
  assign digit2 = digit_r[2];
  assign digit3 = digit_r[3];

endmodule
`default_nettype wire

// File: tb/tb_seg_capture_decoder.sv
`default_nettype none
// tb_seg_capture_decoder: directed and randomized segment-bus stimulus checked against
// a digit/frame model built from the display-path rules.
module tb_seg_capture_decoder;

  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg = 7'b1111111;
  logic [3:0] an  = 4'hF;
  logic [4:0] digit0, digit1, digit2, digit3;
  logic       frame_done;
  logic [9:0] value;
  logic       value_ok;
  logic       err;

  seg_capture_decoder #(.SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg        (seg),
    .an         (an),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .frame_done (frame_done),
    .value      (value),
    .value_ok   (value_ok),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int frames_seen = 0;

  always @(negedge clk) if (frame_done === 1'b1) frames_seen++;

  // Glyph table indexed by code: 0..15 hex, 16 OFF, 17 DASH.
  logic [6:0] glyph [18] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
    7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000, 7'b1111111, 7'b1111110
  };

  int m_digit [4];
  int m_seen;
  bit m_err;
  int m_value;
  bit m_ok;
  int m_frames = 0;

  function automatic int model_decode(input logic [6:0] p);
    for (int i = 0; i < 18; i++) if (glyph[i] == p) return i;
    return 31;
  endfunction

  function automatic int zero_count(input logic [3:0] a);
    int z = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) z++;
    return z;
  endfunction

  function automatic int low_index(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (!a[i]) return i;
    return 0;
  endfunction

  function automatic bit digit_numeric(input int c);
    return (c <= 9) || (c == 16);
  endfunction

  function automatic int digit_num(input int c);
    return (c <= 9) ? c : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_digit[i] = 16;
    m_seen = 0; m_err = 0; m_value = 0; m_ok = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".digit0"}, 32'(digit0), 32'(m_digit[0]));
    chk({tag, ".digit1"}, 32'(digit1), 32'(m_digit[1]));
    chk({tag, ".digit2"}, 32'(digit2), 32'(m_digit[2]));
    chk({tag, ".digit3"}, 32'(digit3), 32'(m_digit[3]));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".frames"}, 32'(frames_seen), 32'(m_frames));
    chk({tag, ".value"}, 32'(value), 32'(m_value));
    chk({tag, ".value_ok"}, 32'(value_ok), 32'(m_ok));
  endtask

  // Drive select a with pattern p1 for h1 cycles then p2 for h2 cycles, then blank for gap cycles.
  task automatic step_split(input string tag, input logic [3:0] a, input logic [6:0] p1, input int h1,
                            input logic [6:0] p2, input int h2, input int gap);
    int hold;
    logic [6:0] sampled;
    an = a; seg = p1;
    repeat (h1) @(negedge clk);
    seg = p2;
    repeat (h2) @(negedge clk);
    an = 4'hF;
    repeat (gap) @(negedge clk);
    hold = h1 + h2;
    // The captured pattern is the one on the pins SETTLE cycles after the select edge.
    sampled = (h1 > SETTLE) ? p1 : p2;
    if (a != 4'hF && zero_count(a) != 1) m_err = 1;
    if (zero_count(a) == 1 && hold >= SETTLE + 1) begin
      m_digit[low_index(a)] = model_decode(sampled);
      if (m_digit[low_index(a)] == 31) m_err = 1;
      m_seen = m_seen | (1 << low_index(a));
      if (m_seen == 15) begin
        m_seen = 0;
        m_frames++;
        m_ok = digit_numeric(m_digit[2]) && digit_numeric(m_digit[1]) && digit_numeric(m_digit[0]);
        m_value = m_ok ? digit_num(m_digit[2]) * 100 + digit_num(m_digit[1]) * 10 + digit_num(m_digit[0]) : 0;
      end
    end
    check_all(tag);
  endtask

  task automatic step(input string tag, input logic [3:0] a, input logic [6:0] p, input int hold);
    step_split(tag, a, p, hold, p, 0, 3);
  endtask

  task automatic do_reset();
    an = 4'hF; seg = 7'b1111111;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [3:0] ra;
    logic [6:0] rp;
    int rh;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all("reset");

    repeat (5000) @(negedge clk);
    check_all("idle");

    step("f1.d0", 4'b1110, glyph[7], 10);
    step("f1.d1", 4'b1101, glyph[4], 10);
    step("f1.d2", 4'b1011, glyph[1], 10);
    step("f1.d3", 4'b0111, glyph[16], 10);
    chk("f1.value147", 32'(value), 32'd147);

    step("short.d1", 4'b1101, glyph[9], 3);
    step("boundary.hold_eq", 4'b0111, glyph[5], SETTLE);
    step("boundary.hold_p1", 4'b0111, glyph[5], SETTLE + 1);
    step_split("segchange", 4'b1110, glyph[3], 2, glyph[9], 8, 3);

    step("f2.d0", 4'b1110, glyph[5], 10);
    step("f2.d1", 4'b1101, glyph[0], 10);
    step("f2.d2", 4'b1011, glyph[12], 10);
    step("f2.d3", 4'b0111, glyph[2], 10);

    step("inv.d2", 4'b1011, 7'b1010101, 10);
    step("f3.d0", 4'b1110, glyph[1], 10);
    step("f3.d1", 4'b1101, glyph[2], 10);
    step("f3.d2", 4'b1011, glyph[3], 10);
    step("f3.d3", 4'b0111, glyph[17], 10);

    do_reset();
    check_all("rst0");
    step("p.d0", 4'b1110, glyph[8], 10);
    step("p.d1", 4'b1101, glyph[8], 10);
    step("p.d2", 4'b1011, glyph[8], 10);
    do_reset();
    check_all("rst_midframe");
    step("p2.d3", 4'b0111, glyph[6], 10);
    check_all("no_stale_frame");
    step("badsel", 4'b1100, glyph[0], 3);

    do_reset();
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        ra = 4'(1 << $urandom_range(0, 3)) | 4'(1 << $urandom_range(0, 3));
      end else begin
        ra = ~(4'(1 << $urandom_range(0, 3)));
      end
      if ($urandom_range(0, 9) < 8) rp = glyph[$urandom_range(0, 17)];
      else rp = 7'($urandom);
      rh = ($urandom_range(0, 3) == 0) ? $urandom_range(1, SETTLE) : $urandom_range(SETTLE + 1, SETTLE + 6);
      step_split("rand", ra, rp, rh, rp, 0, $urandom_range(3, 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
